// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: format codes,
// capture FSM encoding and RGB565 field positions.
package cam_pkg;

    localparam int MODE_RGB332 = 0;
    localparam int MODE_RGB444 = 1;
    localparam int MODE_GRAY8  = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_VS_HI = 2'd1,
        ST_WAIT_VS_LO = 2'd2,
        ST_CAPTURE    = 2'd3
    } cam_state_e;

    // Bit positions inside the 16-bit {hi, lo} RGB565 word.
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

endpackage

// File: rtl/cam_read_gen_if.sv
// Frame-buffer write port: address, 12-bit pixel and write strobe.
// The capture block is the master, the dual-port RAM the slave.
interface cam_read_gen_if #(
    parameter int AW = 15
);
    logic [AW-1:0] mem_px_addr;
    logic [11:0]   mem_px_data;
    logic          px_wr;

    modport master (output mem_px_addr, mem_px_data, px_wr);
    modport slave  (input  mem_px_addr, mem_px_data, px_wr);
endinterface

// File: rtl/cam_px_conv.sv
// Combinational RGB565 {hi, lo} to 12-bit pixel converter.
// MODE picks RGB332, RGB444 or 8-bit gray; shared with the display path.
module cam_px_conv
    import cam_pkg::*;
#(
    parameter int MODE = MODE_RGB332
) (
    input  logic [7:0]  hi,
    input  logic [7:0]  lo,
    output logic [11:0] data
);
    logic [15:0] px;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [9:0]  sum;

    assign px = {hi, lo};
    assign r  = px[R_MSB:R_LSB];
    assign g  = px[G_MSB:G_LSB];
    assign b  = px[B_MSB:B_LSB];

    // Channels widened to 8 bits by replicating their top bits.
    assign r8  = {r, r[4:2]};
    assign g8  = {g, g[5:4]};
    assign b8  = {b, b[4:2]};
    assign sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};

    always_comb begin
        data = '0;
        case (MODE)
            MODE_RGB444: data = {r[4:1], g[5:2], b[4:1]};
            MODE_GRAY8:  data = {2'b00, sum >> 2};
            default:     data = {4'h0, r[4:2], g[5:3], b[4:3]};
        endcase
    end
endmodule

// File: rtl/cam_read_gen.sv
// OV7670-style capture: RGB565 byte pairs -> converted pixels -> frame buffer.
// Define CAM_READ_DECIM_EN to add the decim input for 2x2 decimation.
module cam_read_gen
    import cam_pkg::*;
#(
    parameter int AW         = 15,
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int MODE       = MODE_RGB332,
    parameter int CONTINUOUS = 0,
    parameter int LW         = 8
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          inicio,
`ifdef CAM_READ_DECIM_EN
    input  logic          decim,
`endif
    cam_read_gen_if.master mem,
    output logic [LW-1:0] cont_href,
    output logic          busy,
    output logic          frame_done,
    output logic          ovf
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
    localparam logic [AW-1:0] FULL    = AW'(IMG_W * IMG_H);
    localparam logic [LW-1:0] LN_MAX  = LW'(IMG_H);

    cam_state_e    state, state_nx;
    logic          start, fin;
    logic          cap, pix, line_end, keep, room, wr_ok;
    logic          href_q, phase, line_wr, wr;
    logic [7:0]    hi;
    logic [CW-1:0] col;
    logic [AW-1:0] addr;
    logic [11:0]   conv, data;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        fin      = 1'b0;
        unique case (state)
            ST_IDLE:       if (inicio) state_nx = ST_WAIT_VS_HI;
            ST_WAIT_VS_HI: if (vsync)  state_nx = ST_WAIT_VS_LO;
            ST_WAIT_VS_LO: begin
                if (!vsync) begin
                    state_nx = ST_CAPTURE;
                    start    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (vsync) begin
                    fin      = 1'b1;
                    state_nx = (CONTINUOUS != 0 && inicio) ? ST_WAIT_VS_LO
                                                           : ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // A vsync rise mid-line ends the frame, so bytes are only taken with vsync low.
    assign cap      = (state == ST_CAPTURE) && !vsync;
    assign pix      = cap && href && phase;
    assign line_end = cap && href_q && !href;
    assign room     = (col < COL_MAX) && (addr < FULL);
    assign wr_ok    = pix && keep && room;

`ifdef CAM_READ_DECIM_EN
    logic px_par, ln_par;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            px_par <= 1'b0;
            ln_par <= 1'b0;
        end else if (start) begin
            px_par <= 1'b0;
            ln_par <= 1'b0;
        end else if (line_end) begin
            px_par <= 1'b0;
            ln_par <= ~ln_par;
        end else if (pix) begin
            px_par <= ~px_par;
        end
    end

    assign keep = ~decim | (~px_par & ~ln_par);
`else
    assign keep = 1'b1;
`endif

    cam_px_conv #(.MODE(MODE)) u_conv (
        .hi   (hi),
        .lo   (px_data),
        .data (conv)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            href_q     <= 1'b0;
            phase      <= 1'b0;
            line_wr    <= 1'b0;
            hi         <= '0;
            col        <= '0;
            addr       <= '0;
            data       <= '0;
            wr         <= 1'b0;
            cont_href  <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            href_q     <= href;
            wr         <= wr_ok;
            frame_done <= fin;
            if (wr) addr <= addr + 1'b1;
            if (cap && href && !phase) begin
                hi    <= px_data;
                phase <= 1'b1;
            end
            if (pix) phase <= 1'b0;
            if (wr_ok) begin
                data    <= conv;
                line_wr <= 1'b1;
                col     <= col + 1'b1;
            end
            if (pix && keep && !room) ovf <= 1'b1;
            if (line_end) begin
                phase   <= 1'b0;
                col     <= '0;
                line_wr <= 1'b0;
                if (phase) ovf <= 1'b1;
                if (line_wr) begin
                    if (cont_href == LN_MAX) ovf <= 1'b1;
                    else cont_href <= cont_href + 1'b1;
                end
            end
            if (start) begin
                addr      <= '0;
                cont_href <= '0;
                ovf       <= 1'b0;
                phase     <= 1'b0;
                col       <= '0;
                line_wr   <= 1'b0;
            end
        end
    end

    assign busy            = (state != ST_IDLE);
    assign mem.mem_px_addr = addr;
    assign mem.mem_px_data = data;
    assign mem.px_wr       = wr;
endmodule

// File: tb/tb_cam_read_gen.sv
// Randomised frame-level bench: three cam_read_gen variants share one camera
// stream and are scored against a per-frame model of the stored pixels.
module tb_cam_read_gen;
    import cam_pkg::*;

    localparam int P_W [3] = '{4, 4, 6};
    localparam int P_H [3] = '{3, 3, 4};
    localparam int P_M [3] = '{MODE_RGB332, MODE_RGB444, MODE_GRAY8};
    localparam int P_C [3] = '{0, 1, 0};

    logic        pclk = 1'b0;
    logic        rst, vsync, href, inicio;
    logic [7:0]  px_data;
`ifdef CAM_READ_DECIM_EN
    logic        decim = 1'b0;
`endif
    logic [7:0]  ch [3];
    logic        bz [3], fd [3], ov [3], wr [3];
    logic [14:0] ad [3];
    logic [11:0] dt [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_cnt [3] = '{0, 0, 0};
    logic [26:0] got_q [3][$];
    logic [26:0] exp_q [3][$];
    bit          cap [3] = '{0, 0, 0};
    int          e_addr [3] = '{0, 0, 0};
    int          e_ln [3] = '{0, 0, 0};
    int          e_fd [3] = '{0, 0, 0};
    bit          e_ov [3] = '{0, 0, 0};
    logic [7:0]  fb [6][16];
    int          fn [6];
    int          nl;

    always #5 pclk = ~pclk;

    cam_read_gen_if #(.AW(15)) m0 ();
    cam_read_gen_if #(.AW(15)) m1 ();
    cam_read_gen_if #(.AW(15)) m2 ();

    cam_read_gen #(.AW(15), .IMG_W(4), .IMG_H(3), .MODE(0),
                   .CONTINUOUS(0), .LW(8)) u0 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href),
        .px_data(px_data), .inicio(inicio),
`ifdef CAM_READ_DECIM_EN
        .decim(decim),
`endif
        .mem(m0), .cont_href(ch[0]), .busy(bz[0]),
        .frame_done(fd[0]), .ovf(ov[0]));

    cam_read_gen #(.AW(15), .IMG_W(4), .IMG_H(3), .MODE(1),
                   .CONTINUOUS(1), .LW(8)) u1 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href),
        .px_data(px_data), .inicio(inicio),
`ifdef CAM_READ_DECIM_EN
        .decim(decim),
`endif
        .mem(m1), .cont_href(ch[1]), .busy(bz[1]),
        .frame_done(fd[1]), .ovf(ov[1]));

    cam_read_gen #(.AW(15), .IMG_W(6), .IMG_H(4), .MODE(2),
                   .CONTINUOUS(0), .LW(8)) u2 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href),
        .px_data(px_data), .inicio(inicio),
`ifdef CAM_READ_DECIM_EN
        .decim(decim),
`endif
        .mem(m2), .cont_href(ch[2]), .busy(bz[2]),
        .frame_done(fd[2]), .ovf(ov[2]));

    assign wr[0] = m0.px_wr;
    assign wr[1] = m1.px_wr;
    assign wr[2] = m2.px_wr;
    assign ad[0] = m0.mem_px_addr;
    assign ad[1] = m1.mem_px_addr;
    assign ad[2] = m2.mem_px_addr;
    assign dt[0] = m0.mem_px_data;
    assign dt[1] = m1.mem_px_data;
    assign dt[2] = m2.mem_px_data;

    always @(negedge pclk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr[i] === 1'b1) got_q[i].push_back({ad[i], dt[i]});
            if (fd[i] === 1'b1) fd_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    function automatic logic [11:0] pix_ref(input int mode,
                                            input logic [7:0] h,
                                            input logic [7:0] l);
        int r, g, b;
        r = int'(h) >> 3;
        g = ((int'(h) & 7) << 3) | (int'(l) >> 5);
        b = int'(l) & 31;
        case (mode)
            0:       return 12'((r >> 2) * 32 + (g >> 3) * 4 + (b >> 3));
            1:       return 12'((r >> 1) * 256 + (g >> 2) * 16 + (b >> 1));
            default: return 12'(((r * 8 + r / 4) + 2 * (g * 4 + g / 16)
                                 + (b * 8 + b / 4)) / 4);
        endcase
    endfunction

    task automatic model_frame(input int i);
        int a, ln, w, h, np;
        bit ovr, wrote;
        w = P_W[i];
        h = P_H[i];
        a = 0;
        ln = 0;
        ovr = 0;
        for (int l = 0; l < nl; l++) begin
            np = fn[l] / 2;
            wrote = 0;
            if (fn[l] % 2 != 0) ovr = 1;
            for (int p = 0; p < np; p++) begin
                if (p >= w || a >= w * h) begin
                    ovr = 1;
                end else begin
                    exp_q[i].push_back({a[14:0],
                        pix_ref(P_M[i], fb[l][2*p], fb[l][2*p+1])});
                    a++;
                    wrote = 1;
                end
            end
            if (wrote) begin
                if (ln == h) ovr = 1;
                else ln++;
            end
        end
        e_addr[i] = a;
        e_ln[i] = ln;
        e_ov[i] = ovr;
    endtask

    // Ends the current frame with a vsync pulse; inicio is offered only
    // on the first vsync-high cycle, so a one-shot unit that just finished
    // a frame cannot re-arm for the next one.
    task automatic boundary(input bit go);
        bit nx [3];
        for (int i = 0; i < 3; i++) begin
            e_fd[i] += int'(cap[i]);
            nx[i] = go && (P_C[i] != 0 || !cap[i]);
        end
        vsync = 1'b1;
        inicio = go;
        tick(1);
        inicio = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_nwr", i), got_q[i].size(), exp_q[i].size());
            while (got_q[i].size() > 0 && exp_q[i].size() > 0)
                check($sformatf("u%0d_wr", i), got_q[i].pop_front(),
                      exp_q[i].pop_front());
            got_q[i].delete();
            exp_q[i].delete();
            check($sformatf("u%0d_addr", i), ad[i], e_addr[i]);
            check($sformatf("u%0d_lines", i), ch[i], e_ln[i]);
            check($sformatf("u%0d_ovf", i), ov[i], e_ov[i]);
            check($sformatf("u%0d_fdone", i), fd_cnt[i], e_fd[i]);
            check($sformatf("u%0d_busy", i), bz[i], nx[i]);
            cap[i] = nx[i];
        end
    endtask

    task automatic drive_frame();
        vsync = 1'b0;
        tick(2);
        for (int l = 0; l < nl; l++) begin
            href = 1'b1;
            for (int b = 0; b < fn[l]; b++) begin
                px_data = fb[l][b];
                tick(1);
            end
            href = 1'b0;
            px_data = 8'h00;
            tick(int'($urandom_range(2, 3)));
        end
        for (int i = 0; i < 3; i++)
            if (cap[i]) model_frame(i);
    endtask

    task automatic rand_frame();
        nl = int'($urandom_range(1, 5));
        for (int l = 0; l < nl; l++) begin
            fn[l] = int'($urandom_range(1, 15));
            for (int b = 0; b < fn[l]; b++) fb[l][b] = 8'($urandom);
        end
    endtask

    initial begin
        rst = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        inicio = 1'b0;
        px_data = 8'h00;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_rst_busy", i), bz[i], 0);
            check($sformatf("u%0d_rst_wr", i), wr[i], 0);
            check($sformatf("u%0d_rst_addr", i), ad[i], 0);
            check($sformatf("u%0d_rst_data", i), dt[i], 0);
            check($sformatf("u%0d_rst_lines", i), ch[i], 0);
            check($sformatf("u%0d_rst_ovf", i), ov[i], 0);
            check($sformatf("u%0d_rst_fdone", i), fd[i], 0);
        end
        rst = 1'b1;
        tick(2);

        // Red pixels x4, then white and pure green.
        nl = 2;
        fn[0] = 8;
        for (int b = 0; b < 8; b++) fb[0][b] = (b % 2 == 0) ? 8'hF8 : 8'h00;
        fn[1] = 4;
        fb[1][0] = 8'hFF;
        fb[1][1] = 8'hFF;
        fb[1][2] = 8'h07;
        fb[1][3] = 8'hE0;
        boundary(1'b1);
        drive_frame();

        // Over-long line and odd-length line.
        nl = 2;
        fn[0] = 12;
        fn[1] = 7;
        for (int l = 0; l < 2; l++)
            for (int b = 0; b < 16; b++) fb[l][b] = 8'($urandom);
        boundary(1'b1);
        drive_frame();

        repeat (12) begin
            rand_frame();
            boundary($urandom_range(0, 3) != 0);
            drive_frame();
        end
        boundary(1'b0);

        // Asynchronous reset in the middle of a captured line.
        boundary(1'b1);
        vsync = 1'b0;
        tick(2);
        href = 1'b1;
        for (int b = 0; b < 5; b++) begin
            px_data = 8'($urandom);
            tick(1);
        end
        rst = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_mid_busy", i), bz[i], 0);
            check($sformatf("u%0d_mid_wr", i), wr[i], 0);
            check($sformatf("u%0d_mid_addr", i), ad[i], 0);
            got_q[i].delete();
        end
        tick(1);
        rst = 1'b1;
        for (int b = 0; b < 6; b++) begin
            px_data = 8'($urandom);
            tick(1);
        end
        href = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_post_nwr", i), got_q[i].size(), 0);
            check($sformatf("u%0d_post_busy", i), bz[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
